// File: rtl/fifo_out_ctrl_if.sv
// Handshake bundle between the conv output FIFO controller and its MAC,
// memory and AXI-stream neighbours.
interface fifo_out_ctrl_if #(
   parameter int DEPTH = 19
);
   localparam int LOGDEPTH = $clog2(DEPTH);
   localparam int CNTW     = $clog2(DEPTH + 1);

   logic                alloc_req;
   logic                alloc_gnt;
   logic                wr_valid;
   logic                mem_wr_en;
   logic [LOGDEPTH-1:0] mem_wr_addr;
   logic [LOGDEPTH-1:0] mem_rd_addr;
   logic                OUT_AXIS_TVALID;
   logic                OUT_AXIS_TREADY;
   logic [CNTW-1:0]     occupancy;
   logic [CNTW-1:0]     reserved;
   logic                err_overflow;
   logic                err_unreserved;

   modport master (
      output alloc_req, wr_valid, OUT_AXIS_TREADY,
      input  alloc_gnt, mem_wr_en, mem_wr_addr, mem_rd_addr, OUT_AXIS_TVALID,
             occupancy, reserved, err_overflow, err_unreserved
   );

   modport slave (
      input  alloc_req, wr_valid, OUT_AXIS_TREADY,
      output alloc_gnt, mem_wr_en, mem_wr_addr, mem_rd_addr, OUT_AXIS_TVALID,
             occupancy, reserved, err_overflow, err_unreserved
   );
endinterface

// File: rtl/fifo_out_ctrl.sv
// Pointer/credit controller for the conv output FIFO: slot reservation for the
// non-stallable MAC, memory address generation and AXI-stream valid.
module fifo_out_ctrl #(
   parameter int DEPTH = 19
) (
   input  logic            clk,
   input  logic            reset,
   fifo_out_ctrl_if.slave  bus
);
   localparam int LOGDEPTH = $clog2(DEPTH);
   localparam int CNTW     = $clog2(DEPTH + 1);
   localparam logic [LOGDEPTH-1:0] LAST    = LOGDEPTH'(DEPTH - 1);
   localparam logic [CNTW-1:0]     DEPTH_C = CNTW'(DEPTH);

   logic [LOGDEPTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNTW-1:0]     occ_q, occ_d, res_q, res_d;
   logic                tvalid_q, tvalid_d;
   logic                err_ovf_q, err_ovf_d, err_unres_q, err_unres_d;
   logic                push, pop, gnt;
   logic [CNTW:0]       committed;

   function automatic logic [LOGDEPTH-1:0] inc(input logic [LOGDEPTH-1:0] p);
      return (p == LAST) ? '0 : p + LOGDEPTH'(1);
   endfunction

   always_comb begin
      pop       = tvalid_q & bus.OUT_AXIS_TREADY;
      push      = reset & bus.wr_valid & (occ_q < DEPTH_C);
      committed = {1'b0, occ_q} + {1'b0, res_q};
      // No credit for a same-cycle pop, so a granted slot is always free at write time.
      gnt       = reset & bus.alloc_req & (committed < {1'b0, DEPTH_C});

      res_d = res_q;
      if (gnt)
         res_d = res_d + CNTW'(1);
      if (bus.wr_valid && (res_q != '0))
         res_d = res_d - CNTW'(1);

      occ_d = occ_q;
      if (push)
         occ_d = occ_d + CNTW'(1);
      if (pop)
         occ_d = occ_d - CNTW'(1);

      head_d      = pop  ? inc(head_q) : head_q;
      tail_d      = push ? inc(tail_q) : tail_q;
      tvalid_d    = (occ_d != '0);
      err_ovf_d   = err_ovf_q   | (bus.wr_valid & (occ_q == DEPTH_C));
      err_unres_d = err_unres_q | (bus.wr_valid & (res_q == '0));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         res_q       <= '0;
         tvalid_q    <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unres_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         res_q       <= res_d;
         tvalid_q    <= tvalid_d;
         err_ovf_q   <= err_ovf_d;
         err_unres_q <= err_unres_d;
      end
   end

   // Reading the next head one cycle early lets the 1-cycle memory keep up with
   // back-to-back pops; on an empty FIFO rd_addr==wr_addr and the bypass serves it.
   assign bus.mem_rd_addr     = reset ? head_d : '0;
   assign bus.mem_wr_en       = push;
   assign bus.mem_wr_addr     = tail_q;
   assign bus.alloc_gnt       = gnt;
   assign bus.OUT_AXIS_TVALID = tvalid_q;
   assign bus.occupancy       = occ_q;
   assign bus.reserved        = res_q;
   assign bus.err_overflow    = err_ovf_q;
   assign bus.err_unreserved  = err_unres_q;
endmodule
